// File: rtl/bcd_serial_encoder.sv
// bcd_serial_encoder: sequential binary-to-BCD converter using shift-add-3
// (double dabble), one input bit per clock. It has a start/done handshake,
// saturates to all nines on overflow, and blanks leading zeros on digit_en.
module bcd_serial_encoder #(
  parameter int W   = 8,
  parameter int D   = 4,
  parameter bit LZB = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     in,
  output logic             busy,
  output logic             done,
  output logic [4*D-1:0]   digits,
  output logic [D-1:0]     digit_en,
  output logic             overflow
);

  localparam int             CW       = $clog2(W + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(W);
  localparam logic [CW-1:0]  CNT_LAST = CW'(1);
  localparam logic [D-1:0]   EN_RESET = D'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [4*D-1:0]   scratch_q, scratch_d;
  logic             ovf_int_q, ovf_int_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4*D-1:0]   digits_q, digits_d;
  logic [D-1:0]     digit_en_q, digit_en_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  // Datapath helpers for the shift step.
  logic [4*D-1:0]   corr;
  logic [4*D+W-1:0] shifted;
  logic             final_ovf;
  logic [4*D-1:0]   final_digits;
  logic [D-1:0]     lz_en;
  logic [D-1:0]     en_calc;

  // Add-3 correction, each nibble on its own; no carry crosses nibbles.
  for (genvar gi = 0; gi < D; gi++) begin : g_corr
    assign corr[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                           ? scratch_q[4*gi +: 4] + 4'd3
                           : scratch_q[4*gi +: 4];
  end

  // One combined left shift of {scratch, binary}; scratch MSB falls out.
  assign shifted      = {corr, shift_q} << 1;
  assign final_ovf    = ovf_int_q | corr[4*D-1];
  assign final_digits = final_ovf ? {D{4'h9}} : shifted[4*D+W-1:W];

  // Digit k is lit when it or any more significant digit is nonzero.
  for (genvar gi = 0; gi < D; gi++) begin : g_lz
    if (gi == 0) begin : g_ones
      assign lz_en[gi] = 1'b1;
    end else begin : g_upper
      assign lz_en[gi] = |final_digits[4*D-1:4*gi];
    end
  end

  assign en_calc = (final_ovf || !LZB) ? {D{1'b1}} : lz_en;

  // Next-state and result computation for the IDLE/SHIFT controller.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_int_d  = ovf_int_q;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    digit_en_d = digit_en_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = in;
          scratch_d = '0;
          ovf_int_d = 1'b0;
          cnt_d     = CNT_LOAD;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shifted[4*D+W-1:W];
        shift_d   = shifted[W-1:0];
        ovf_int_d = final_ovf;
        cnt_d     = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          digits_d   = final_digits;
          digit_en_d = en_calc;
          overflow_d = final_ovf;
          done_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_int_q  <= 1'b0;
      cnt_q      <= '0;
      digits_q   <= '0;
      digit_en_q <= EN_RESET;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_int_q  <= ovf_int_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      digit_en_q <= digit_en_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign digits   = digits_q;
  assign digit_en = digit_en_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_serial_encoder.sv
// tb_bcd_serial_encoder: scoreboard bench for four configurations of the
// converter (8/4/LZB, 8/4/no-LZB, 16/4, 12/3) selected through one mux.
module tb_bcd_serial_encoder;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  en;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_bus = '0;
  int          sel = 0;

  int errors = 0;
  int checks = 0;
  exp_t sb_q[$];

  logic        start_a, start_b, start_c, start_d;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        done_a, done_b, done_c, done_d;
  logic [15:0] dig_a, dig_b, dig_c;
  logic [11:0] dig_d;
  logic [3:0]  en_a, en_b, en_c;
  logic [2:0]  en_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;

  logic [15:0] obs_dig;
  logic [3:0]  obs_en;
  logic        obs_ovf, obs_done, obs_busy;

  always #5 clk = ~clk;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);
  assign start_d = start && (sel == 3);

  bcd_serial_encoder #(.W(8), .D(4), .LZB(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in(in_bus[7:0]),
    .busy(busy_a), .done(done_a), .digits(dig_a), .digit_en(en_a), .overflow(ovf_a));
  bcd_serial_encoder #(.W(8), .D(4), .LZB(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in(in_bus[7:0]),
    .busy(busy_b), .done(done_b), .digits(dig_b), .digit_en(en_b), .overflow(ovf_b));
  bcd_serial_encoder #(.W(16), .D(4), .LZB(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .in(in_bus),
    .busy(busy_c), .done(done_c), .digits(dig_c), .digit_en(en_c), .overflow(ovf_c));
  bcd_serial_encoder #(.W(12), .D(3), .LZB(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .in(in_bus[11:0]),
    .busy(busy_d), .done(done_d), .digits(dig_d), .digit_en(en_d), .overflow(ovf_d));

  // Route the selected instance onto common observation signals.
  always_comb begin
    obs_dig = '0; obs_en = '0; obs_ovf = 1'b0; obs_done = 1'b0; obs_busy = 1'b0;
    case (sel)
      0: begin obs_dig = dig_a; obs_en = en_a; obs_ovf = ovf_a; obs_done = done_a; obs_busy = busy_a; end
      1: begin obs_dig = dig_b; obs_en = en_b; obs_ovf = ovf_b; obs_done = done_b; obs_busy = busy_b; end
      2: begin obs_dig = dig_c; obs_en = en_c; obs_ovf = ovf_c; obs_done = done_c; obs_busy = busy_c; end
      default: begin obs_dig = {4'h0, dig_d}; obs_en = {1'b0, en_d}; obs_ovf = ovf_d; obs_done = done_d; obs_busy = busy_d; end
    endcase
  end

  function automatic int w_of(input int s);
    case (s)
      2: return 16;
      3: return 12;
      default: return 8;
    endcase
  endfunction

  // Decimal reference: digits by repeated division, not by double dabble.
  function automatic exp_t model(input int unsigned value, input int s);
    exp_t e;
    int nd, top;
    bit lz;
    int unsigned lim, v;
    nd = (s == 3) ? 3 : 4;
    lz = (s != 1);
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    e.dig = '0; e.en = '0; e.ovf = 1'b0;
    if (value >= lim) begin
      e.ovf = 1'b1;
      for (int k = 0; k < nd; k++) begin
        e.dig[4*k +: 4] = 4'h9;
        e.en[k] = 1'b1;
      end
    end else begin
      v = value; top = 0;
      for (int k = 0; k < nd; k++) begin
        e.dig[4*k +: 4] = 4'(v % 10);
        if ((v % 10) != 0) top = k;
        v = v / 10;
      end
      for (int k = 0; k < nd; k++) e.en[k] = (!lz) || (k <= top);
    end
    return e;
  endfunction

  // Pulse start for one accepting edge, push the expectation, wait for done.
  task automatic do_conv(input logic [15:0] value, output int g_lat,
                         output int g_busy, output logic g_to);
    int cyc;
    @(negedge clk);
    in_bus = value;
    start  = 1'b1;
    sb_q.push_back(model(value, sel));
    @(negedge clk);
    start  = 1'b0;
    in_bus = ~value;
    cyc = 0; g_busy = 0; g_to = 1'b0;
    while (!obs_done && cyc <= 200) begin
      if (obs_busy) g_busy++;
      @(negedge clk);
      cyc++;
    end
    g_to  = !obs_done;
    g_lat = cyc;
    $display("conv sel=%0d in=%0d digits=%h en=%b ovf=%b lat=%0d",
             sel, value, obs_dig, obs_en, obs_ovf, cyc);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checks++;
      if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags sel=%0d busy=%b done=%b ovf=%b required 0 0 0", s, obs_busy, obs_done, obs_ovf);
      end
      checks++;
      if (obs_dig !== 16'h0000 || obs_en !== 4'b0001) begin
        errors++;
        $display("FAIL reset_out sel=%0d digits=%h en=%b required 0000 0001", s, obs_dig, obs_en);
      end
    end
    sel = 0;
  endtask

  task automatic test_max_value();
    int lat, bcnt; logic to; exp_t e;
    sel = 0;
    do_conv(16'd255, lat, bcnt, to);
    e = sb_q.pop_front();
    checks++;
    if (to || lat !== 8) begin errors++; $display("FAIL max_latency got=%0d timeout=%b required 8", lat, to); end
    checks++;
    if (bcnt !== 8) begin errors++; $display("FAIL max_busy got=%0d required 8", bcnt); end
    checks++;
    if (obs_dig !== e.dig || e.dig !== 16'h0255) begin errors++; $display("FAIL max_digits got=%h required 0255", obs_dig); end
    checks++;
    if (obs_en !== 4'b0111 || obs_ovf !== 1'b0) begin errors++; $display("FAIL max_en got=%b ovf=%b required 0111 0", obs_en, obs_ovf); end
    @(negedge clk);
    checks++;
    if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin errors++; $display("FAIL max_done_pulse done=%b busy=%b required 0 0", obs_done, obs_busy); end
    checks++;
    if (obs_dig !== 16'h0255) begin errors++; $display("FAIL max_hold got=%h required 0255", obs_dig); end
  endtask

  task automatic test_zero();
    int lat, bcnt; logic to; exp_t e;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_conv(16'd0, lat, bcnt, to);
      e = sb_q.pop_front();
      checks++;
      if (to || obs_dig !== e.dig || obs_ovf !== e.ovf) begin
        errors++; $display("FAIL zero_digits sel=%0d got=%h ovf=%b required %h %b", s, obs_dig, obs_ovf, e.dig, e.ovf);
      end
      checks++;
      if (obs_en !== e.en) begin errors++; $display("FAIL zero_en sel=%0d got=%b required %b", s, obs_en, e.en); end
    end
    sel = 0;
  endtask

  task automatic test_overflow();
    int lat, bcnt; logic to; exp_t e;
    logic [15:0] vals [3];
    vals[0] = 16'd12345; vals[1] = 16'd9999; vals[2] = 16'd10000;
    sel = 2;
    for (int i = 0; i < 3; i++) begin
      do_conv(vals[i], lat, bcnt, to);
      e = sb_q.pop_front();
      checks++;
      if (to || lat !== 16) begin errors++; $display("FAIL ovf_latency in=%0d got=%0d required 16", vals[i], lat); end
      checks++;
      if (obs_dig !== e.dig || obs_ovf !== e.ovf || obs_en !== e.en) begin
        errors++;
        $display("FAIL ovf_result in=%0d got=%h/%b/%b required %h/%b/%b", vals[i], obs_dig, obs_en, obs_ovf, e.dig, e.en, e.ovf);
      end
    end
    sel = 0;
  endtask

  task automatic test_back_to_back();
    int cyc; exp_t e;
    sel = 0;
    @(negedge clk);
    in_bus = 16'd200; start = 1'b1;
    sb_q.push_back(model(200, 0));
    sb_q.push_back(model(7, 0));
    @(negedge clk);
    in_bus = 16'd7;
    cyc = 0;
    while (!obs_done && cyc <= 200) begin @(negedge clk); cyc++; end
    e = sb_q.pop_front();
    $display("conv sel=0 in=200 held-start digits=%h en=%b ovf=%b lat=%0d", obs_dig, obs_en, obs_ovf, cyc);
    checks++;
    if (!obs_done || obs_dig !== e.dig || obs_en !== e.en) begin
      errors++; $display("FAIL hold_first got=%h/%b required %h/%b", obs_dig, obs_en, e.dig, e.en);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (obs_busy !== 1'b1) begin errors++; $display("FAIL hold_accept busy=%b required 1", obs_busy); end
    cyc = 1;
    while (!obs_done && cyc <= 200) begin @(negedge clk); cyc++; end
    e = sb_q.pop_front();
    $display("conv sel=0 in=7 back-to-back digits=%h en=%b ovf=%b gap=%0d", obs_dig, obs_en, obs_ovf, cyc);
    checks++;
    if (cyc !== 9) begin errors++; $display("FAIL b2b_gap got=%0d required 9", cyc); end
    checks++;
    if (obs_dig !== e.dig || obs_en !== e.en || e.en !== 4'b0001) begin
      errors++; $display("FAIL b2b_second got=%h/%b required %h/%b", obs_dig, obs_en, e.dig, e.en);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bcnt; logic to; exp_t e; logic saw_done, saw_busy;
    sel = 0;
    saw_done = 1'b0;
    @(negedge clk);
    in_bus = 16'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); saw_done |= obs_done; end
    rst_n = 1'b0;
    @(negedge clk);
    saw_done |= obs_done;
    $display("abort sel=0 in=99 digits=%h en=%b busy=%b", obs_dig, obs_en, obs_busy);
    checks++;
    if (saw_done || obs_busy !== 1'b0) begin errors++; $display("FAIL abort_flags done_seen=%b busy=%b required 0 0", saw_done, obs_busy); end
    checks++;
    if (obs_dig !== 16'h0000 || obs_en !== 4'b0001 || obs_ovf !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got=%h/%b/%b required 0000/0001/0", obs_dig, obs_en, obs_ovf);
    end
    rst_n = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); saw_busy |= obs_busy | obs_done; end
    checks++;
    if (saw_busy) begin errors++; $display("FAIL abort_restart activity=%b required 0", saw_busy); end
    do_conv(16'd42, lat, bcnt, to);
    e = sb_q.pop_front();
    checks++;
    if (to || obs_dig !== e.dig || obs_en !== e.en || e.en !== 4'b0011) begin
      errors++; $display("FAIL abort_next got=%h/%b required %h/%b", obs_dig, obs_en, e.dig, e.en);
    end
    // Reset and start on the same edge: reset wins, nothing captured.
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; in_bus = 16'd5;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    checks++;
    if (obs_busy !== 1'b0 || obs_dig !== 16'h0000) begin
      errors++; $display("FAIL reset_start busy=%b digits=%h required 0 0000", obs_busy, obs_dig);
    end
    @(negedge clk);
    checks++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      errors++; $display("FAIL reset_start_after busy=%b done=%b required 0 0", obs_busy, obs_done);
    end
  endtask

  task automatic test_sweep();
    int lat, bcnt; logic to; exp_t e; logic [15:0] v;
    sel = 3;
    for (int i = 0; i < 1000; i++) begin
      v = (i % 2 == 1) ? 16'($urandom_range(0, 999)) : 16'($urandom_range(0, 4095));
      if (i == 0) v = 16'd999;
      if (i == 2) v = 16'd1000;
      do_conv(v, lat, bcnt, to);
      e = sb_q.pop_front();
      checks++;
      if (to || lat !== w_of(3)) begin errors++; $display("FAIL sweep_latency in=%0d got=%0d required 12", v, lat); end
      checks++;
      if (obs_dig !== e.dig || obs_ovf !== e.ovf) begin
        errors++; $display("FAIL sweep_digits in=%0d got=%h/%b required %h/%b", v, obs_dig, obs_ovf, e.dig, e.ovf);
      end
      checks++;
      if (obs_en !== e.en) begin errors++; $display("FAIL sweep_en in=%0d got=%b required %b", v, obs_en, e.en); end
    end
    sel = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_max_value();
    test_zero();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left got=%0d required 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
